// File: rtl/hw_feature_sampler_pkg.sv
// Feature-vector layout shared by the sampler, its FIFO and downstream consumers.
// vec_data = {ts[31:0], seq[6:0], trig, intensity[7:0], imbalance[15:0]}.
package qa_feature_pkg;

  localparam int unsigned VEC_W = 64;
  localparam int unsigned TS_W  = 32;
  localparam int unsigned SEQ_W = 7;
  localparam int unsigned INT_W = 8;
  localparam int unsigned IMB_W = 16;

  localparam int unsigned IMB_LSB  = 0;
  localparam int unsigned INT_LSB  = IMB_LSB + IMB_W;
  localparam int unsigned TRIG_BIT = INT_LSB + INT_W;
  localparam int unsigned SEQ_LSB  = TRIG_BIT + 1;
  localparam int unsigned TS_LSB   = SEQ_LSB + SEQ_W;

  localparam logic TRIG_PERIODIC = 1'b0;
  localparam logic TRIG_DELTA    = 1'b1;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [SEQ_W-1:0] seq;
    logic             trig;
    logic [INT_W-1:0] intensity;
    logic [IMB_W-1:0] imbalance;
  } feat_vec_t;

  // Unsigned distance between two imbalance readings; one extra bit so it never wraps.
  function automatic logic [IMB_W:0] imb_abs_diff(input logic [IMB_W-1:0] a,
                                                  input logic [IMB_W-1:0] b);
    logic [IMB_W:0] ea;
    logic [IMB_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/hw_sync_fifo.sv
// First-word-fall-through single-clock FIFO; the head is visible while not empty.
// When empty the output holds the most recently popped word.
module hw_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign level   = count;
  assign dout    = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hw_feature_sampler.sv
// Samples feature-engine outputs on a period or on a large imbalance move, timestamps them
// into 64-bit vectors and queues them for the inference engine over valid/ready.
module hw_feature_sampler
  import qa_feature_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 256,
  parameter int unsigned DELTA_THRESH  = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   feat_imbalance,
  input  logic [7:0]                    feat_intensity,
  input  logic                          feat_en,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  output logic [63:0]                   vec_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0]    PERIOD_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [IMB_W:0]   THRESH      = (IMB_W+1)'(DELTA_THRESH);

  logic [TS_W-1:0]  ts;
  logic [SEQ_W-1:0] seq;
  logic [TW-1:0]    timer;
  logic [IMB_W-1:0] last_imb;

  logic             periodic_hit;
  logic             delta_hit;
  logic             sample;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;
  feat_vec_t        sample_vec;

  assign periodic_hit = feat_en && (timer == PERIOD_LAST);
  assign delta_hit    = feat_en && (imb_abs_diff(feat_imbalance, last_imb) >= THRESH);
  assign sample       = periodic_hit || delta_hit;

  always_comb begin
    sample_vec           = '0;
    sample_vec.ts        = ts;
    sample_vec.seq       = seq;
    sample_vec.trig      = delta_hit ? TRIG_DELTA : TRIG_PERIODIC;
    sample_vec.intensity = feat_intensity;
    sample_vec.imbalance = feat_imbalance;
  end

  assign vec_valid = !fifo_empty;
  assign pop       = vec_valid && vec_ready;
  assign drop      = sample && fifo_full && !pop;

  // seq and last_imb advance on every sample, dropped or not, so gaps are visible downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      seq        <= '0;
      timer      <= '0;
      last_imb   <= '0;
      drop_count <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (!feat_en || sample) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (sample) begin
        last_imb <= feat_imbalance;
        seq      <= seq + 1'b1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  hw_sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sample),
    .din   (sample_vec),
    .pop   (pop),
    .dout  (vec_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_hw_feature_sampler.sv
// Scoreboarded bench: expected vectors are queued as stimulus is driven and compared on pop.
module tb_hw_feature_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] feat_imbalance;
  logic [7:0]  feat_intensity;
  logic        feat_en;
  logic        vec_valid;
  logic        vec_ready;
  logic [63:0] vec_data;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  logic        s_rst;
  logic [15:0] s_imb;
  logic [7:0]  s_int;
  logic        s_en;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [3:0]  s_level;
  logic [3:0]  s_drop;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_ts;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  hw_feature_sampler #(
    .SAMPLE_PERIOD (256),
    .DELTA_THRESH  (16),
    .FIFO_DEPTH    (8),
    .CNT_W         (16)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .feat_imbalance (feat_imbalance),
    .feat_intensity (feat_intensity),
    .feat_en        (feat_en),
    .vec_valid      (vec_valid),
    .vec_ready      (vec_ready),
    .vec_data       (vec_data),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  hw_feature_sampler #(
    .SAMPLE_PERIOD (4),
    .DELTA_THRESH  (16),
    .FIFO_DEPTH    (8),
    .CNT_W         (4)
  ) u_small (
    .clk            (clk),
    .rst            (s_rst),
    .feat_imbalance (s_imb),
    .feat_intensity (s_int),
    .feat_en        (s_en),
    .vec_valid      (s_valid),
    .vec_ready      (s_ready),
    .vec_data       (s_data),
    .fifo_level     (s_level),
    .drop_count     (s_drop)
  );

  // Reference cycle counter: value at posedge+1 is the ts the next edge will capture.
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  function automatic logic [63:0] mk_vec(input logic [31:0] ts, input logic [6:0] seq,
                                         input logic trig, input logic [7:0] inten,
                                         input logic [15:0] imb);
    return {ts, seq, trig, inten, imb};
  endfunction

  // Scoreboard: every head transfer must match the oldest expected vector.
  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (!rst && vec_valid && vec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h required no vector", vec_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (vec_data !== exp_v) begin
          errors++;
          $display("FAIL pop_data: got %h required %h", vec_data, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    feat_en = 1'b0;
    vec_ready = 1'b0;
    feat_imbalance = 16'd0;
    feat_intensity = 8'd5;
    step();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    feat_en = 1'b0;
    vec_ready = 1'b0;
    feat_imbalance = 16'd0;
    feat_intensity = 8'd5;
    step();
    checks++;
    if (vec_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0 || vec_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b level=%0d drop=%0d data=%h required all 0",
               vec_valid, fifo_level, drop_count, vec_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    feat_en = 1'b1;
    vec_ready = 1'b1;
    exp_q.push_back(mk_vec(32'd255, 7'd0, 1'b0, 8'd5, 16'd0));
    exp_q.push_back(mk_vec(32'd511, 7'd1, 1'b0, 8'd5, 16'd0));
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL periodic_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_delta();
    logic [31:0] t;
    feat_imbalance = 16'd512;
    exp_q.push_back(mk_vec(tb_ts, 7'd2, 1'b1, 8'd5, 16'd512));
    step();
    feat_imbalance = 16'd520;
    step();
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL delta_below_thresh: got level=%0d required 0", fifo_level);
    end
    feat_imbalance = 16'd530;
    t = tb_ts;
    exp_q.push_back(mk_vec(t, 7'd3, 1'b1, 8'd5, 16'd530));
    exp_q.push_back(mk_vec(t + 32'd256, 7'd4, 1'b0, 8'd5, 16'd530));
    step();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    feat_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL delta_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [63:0] last_v;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      feat_en = 1'b1;
      feat_imbalance = (k % 2 == 0) ? 16'd1000 : 16'd0;
      if (k < 8) exp_q.push_back(mk_vec(tb_ts, 7'(k), 1'b1, 8'd5, feat_imbalance));
      step();
    end
    feat_en = 1'b0;
    last_v = exp_q[7];
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 16'd2 || vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: got level=%0d drop=%0d valid=%b required 8 2 1",
               fifo_level, drop_count, vec_valid);
    end
    step();
    step();
    checks++;
    if (vec_data !== exp_q[0]) begin
      errors++;
      $display("FAIL overflow_frozen: got %h required %h", vec_data, exp_q[0]);
    end
    vec_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (fifo_level !== 4'd0 || vec_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain: got level=%0d valid=%b pending=%0d required 0 0 0",
               fifo_level, vec_valid, exp_q.size());
    end
    checks++;
    if (vec_data !== last_v) begin
      errors++;
      $display("FAIL empty_hold: got %h required %h", vec_data, last_v);
    end
    vec_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 3; k++) begin
      feat_en = 1'b1;
      feat_imbalance = (k == 0) ? 16'd1000 : (k == 1) ? 16'd0 : 16'd20;
      step();
    end
    feat_en = 1'b0;
    step();
    checks++;
    if (fifo_level !== 4'd3 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL prereset_state: got level=%0d drop=%0d required 3 2", fifo_level, drop_count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (vec_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b level=%0d drop=%0d required 0 0 0",
               vec_valid, fifo_level, drop_count);
    end
    exp_q.delete();
    rst = 1'b0;
    feat_en = 1'b1;
    feat_imbalance = 16'd20;
    vec_ready = 1'b1;
    exp_q.push_back(mk_vec(32'd0, 7'd0, 1'b1, 8'd5, 16'd20));
    step();
    feat_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      feat_en = 1'b1;
      feat_imbalance = (k % 2 == 0) ? 16'd1000 : 16'd0;
      exp_q.push_back(mk_vec(tb_ts, 7'(k), 1'b1, 8'd5, feat_imbalance));
      step();
    end
    feat_en = 1'b0;
    step();
    feat_en = 1'b1;
    feat_imbalance = 16'd1000;
    vec_ready = 1'b1;
    exp_q.push_back(mk_vec(tb_ts, 7'd8, 1'b1, 8'd5, 16'd1000));
    step();
    feat_en = 1'b0;
    vec_ready = 1'b0;
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL full_push_pop: got level=%0d drop=%0d required 8 0", fifo_level, drop_count);
    end
    vec_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL full_push_pop_drain: got pending=%0d level=%0d required 0 0",
               exp_q.size(), fifo_level);
    end
    vec_ready = 1'b0;
  endtask

  task automatic test_saturate_wrap();
    logic [6:0] prev;
    logic [6:0] cur;
    bit         got_first;
    bit         wrapped;
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    s_en = 1'b1;
    s_imb = 16'd0;
    s_ready = 1'b0;
    repeat (120) step();
    checks++;
    if (s_drop !== 4'd15 || s_level !== 4'd8) begin
      errors++;
      $display("FAIL drop_saturate: got drop=%0d level=%0d required 15 8", s_drop, s_level);
    end
    s_ready = 1'b1;
    got_first = 1'b0;
    wrapped = 1'b0;
    prev = 7'd0;
    for (int i = 0; i < 800 && !wrapped; i++) begin
      @(negedge clk);
      if (s_valid) begin
        cur = s_data[31:25];
        if (!got_first) begin
          got_first = 1'b1;
          checks++;
          if (s_data[63:32] !== 32'd3 || cur !== 7'd0 || s_data[24] !== 1'b0) begin
            errors++;
            $display("FAIL small_first: got ts=%0d seq=%0d trig=%b required 3 0 0",
                     s_data[63:32], cur, s_data[24]);
          end
        end else if (prev == 7'd127) begin
          wrapped = 1'b1;
          checks++;
          if (cur !== 7'd0) begin
            errors++;
            $display("FAIL seq_wrap: got %0d required 0", cur);
          end
        end
        prev = cur;
      end
    end
    checks++;
    if (!wrapped || s_drop !== 4'd15) begin
      errors++;
      $display("FAIL seq_wrap_seen: got wrapped=%0d drop=%0d required 1 15", wrapped, s_drop);
    end
  endtask

  initial begin
    rst = 1'b1;
    feat_en = 1'b0;
    vec_ready = 1'b0;
    feat_imbalance = 16'd0;
    feat_intensity = 8'd5;
    s_rst = 1'b1;
    s_en = 1'b0;
    s_imb = 16'd0;
    s_int = 8'd7;
    s_ready = 1'b0;
    step();
    test_reset();
    test_periodic();
    test_delta();
    test_overflow();
    test_mid_reset();
    test_full_push_pop();
    test_saturate_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
